adder_pipelined: RTL

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. It generalises the 32-bit combinational adder to any width and splits the carry chain into STAGES registered chunks, so wide adds close timing at high clock rates. It sits between operand producers and result consumers in the datapath and absorbs downstream backpressure without losing or duplicating results.

---
 rtl/adder_pipelined.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/adder_pipelined.sv
// ---------------------------------------------------------------------------
// adder_pipelined
//
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is cut
// into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each stage adds one chunk
// and registers the carry for the next stage. Operand bits that are still
// needed travel forward with the beat. Sum chunks that are already done travel
// forward with the beat too. The pipeline advances as one unit. It stalls
// only when the output slot is full and the consumer is not ready.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth (1 <= STAGES <= WIDTH, WIDTH % STAGES == 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, drops every beat in flight
//   in_valid   operand beat present
//   in_ready   block can take a beat this cycle (combinational from out_ready)
//   num1       operand A
//   num2       operand B
//   C_in       carry-in, ignored when sub=1
//   sub        0: A+B+C_in, 1: A-B computed as A+~B+1
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^WIDTH
//   C_out      carry out of the top bit (for subtract: 1 = no borrow)
//   ovf        signed overflow, present only when ADDER_OVF_EN is defined
//
// Optional feature macro: ADDER_OVF_EN
// ---------------------------------------------------------------------------
module adder_pipelined #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             C_out
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             w_adv;
    logic [WIDTH-1:0] w_numB;

    // Subtraction inverts B here. The +1 enters as the stage-0 carry.
    assign w_numB   = sub ? ~num2 : num2;

    // The whole pipeline moves together whenever the output slot is free or
    // is being drained this cycle.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = rst_n && w_adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        // Operand bits still needed by this stage and the stages after it.
        localparam int IN_W = WIDTH - s * CHUNK;

        logic [IN_W-1:0]        w_inA;
        logic [IN_W-1:0]        w_inB;
        logic                   w_inCarry;
        logic                   w_inValid;
        logic [(s+1)*CHUNK-1:0] w_nextSum;
        logic [CHUNK:0]         w_part;

        logic                   r_valid;
        logic                   r_carry;
        logic [(s+1)*CHUNK-1:0] r_sum;

        // Add the lowest remaining chunk, with the carry from the stage below.
        assign w_part = {1'b0, w_inA[CHUNK-1:0]} + {1'b0, w_inB[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, w_inCarry};

        if (s == 0) begin : g_first
            assign w_inA     = num1;
            assign w_inB     = w_numB;
            assign w_inCarry = sub | C_in;
            assign w_inValid = in_valid && in_ready;
            assign w_nextSum = w_part[CHUNK-1:0];
        end else begin : g_next
            assign w_inA     = g_stage[s-1].g_skew.r_a;
            assign w_inB     = g_stage[s-1].g_skew.r_b;
            assign w_inCarry = g_stage[s-1].r_carry;
            assign w_inValid = g_stage[s-1].r_valid;
            assign w_nextSum = {w_part[CHUNK-1:0], g_stage[s-1].r_sum};
        end

        // Partial sum, carry and valid for this stage. They hold during a stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_inValid;
                r_carry <= w_part[CHUNK];
                r_sum   <= w_nextSum;
            end
        end

        // Operand skew: only the chunks that later stages still need move
        // forward. The last stage has nothing left to forward.
        if (s < STAGES - 1) begin : g_skew
            logic [IN_W-CHUNK-1:0] r_a;
            logic [IN_W-CHUNK-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_inA[IN_W-1:CHUNK];
                    r_b <= w_inB[IN_W-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign C_out     = g_stage[STAGES-1].r_carry;

`ifdef ADDER_OVF_EN
    logic w_aTop;
    logic w_bTop;
    logic w_sumTop;
    logic r_ovf;

    // Overflow uses the operand sign bits that reach the last stage.
    // It is registered at the same time as the top sum chunk.
    assign w_aTop   = g_stage[STAGES-1].w_inA[CHUNK-1];
    assign w_bTop   = g_stage[STAGES-1].w_inB[CHUNK-1];
    assign w_sumTop = g_stage[STAGES-1].w_part[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= (w_aTop == w_bTop) && (w_sumTop != w_aTop);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
